// File: rtl/avmm_ccip_wr_arbiter_if.sv
// rtl/avmm_ccip_wr_arbiter_if.sv - requester-side and bridge-side Avalon-MM write buses of the write arbiter
interface avmm_ccip_wr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 49
);
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0][2:0]        req_burstcount;
  logic [NUM_REQ-1:0]             req_waitrequest;

  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [2:0]        m_burstcount;
  logic              m_waitrequest;

  logic               quiesce;
  logic               idle;
  logic [NUM_REQ-1:0] burst_err;

  // master: the arbiter, which owns the shared host write path
  modport master (
    input  req_write, req_address, req_writedata, req_burstcount, m_waitrequest, quiesce,
    output req_waitrequest, m_write, m_address, m_writedata, m_burstcount, idle, burst_err
  );

  modport slave (
    output req_write, req_address, req_writedata, req_burstcount, m_waitrequest, quiesce,
    input  req_waitrequest, m_write, m_address, m_writedata, m_burstcount, idle, burst_err
  );
endinterface

// File: rtl/avmm_ccip_wr_arbiter.sv
// rtl/avmm_ccip_wr_arbiter.sv - burst-aware round-robin arbiter sharing one host write path among Avalon-MM requesters
module avmm_ccip_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 49
) (
  input  logic                  clk,
  input  logic                  reset,
  avmm_ccip_wr_arbiter_if.master bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]         state;
  logic [1:0]         beats_left;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      owner;
  logic [NUM_REQ-1:0] err_q;

  logic          found;
  logic [GW-1:0] sel;
  logic [GW-1:0] cand;
  logic [GW-1:0] g;
  logic          granted;
  logic [2:0]    bc_raw;
  logic          bc_legal;
  logic          accept;
  int            idx;

  // round-robin search from last_grant+1; quiesce only gates new owners, never a locked burst
  always_comb begin
    found = 1'b0;
    sel   = last_grant;
    cand  = '0;
    idx   = 0;
    if (!bus.quiesce) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx  = (int'(last_grant) + k) % NUM_REQ;
        cand = GW'(idx);
        if (!found && bus.req_write[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  always_comb begin
    if (state == ST_BURST) begin
      g       = owner;
      granted = ~reset;
    end else begin
      g       = sel;
      granted = found & ~reset;
    end
  end

  assign bc_raw   = bus.req_burstcount[g];
  assign bc_legal = (bc_raw == 3'd1) || (bc_raw == 3'd2) || (bc_raw == 3'd4);

  assign bus.m_write      = granted & bus.req_write[g];
  assign bus.m_address    = bus.req_address[g];
  assign bus.m_writedata  = bus.req_writedata[g];
  assign bus.m_burstcount = bc_legal ? bc_raw : 3'd1;

  always_comb begin
    bus.req_waitrequest = '1;
    if (granted) begin
      bus.req_waitrequest[g] = bus.m_waitrequest;
    end
  end

  assign accept        = bus.m_write & ~bus.m_waitrequest;
  assign bus.idle      = (state == ST_IDLE) & ~bus.m_write;
  assign bus.burst_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      beats_left <= 2'd0;
      last_grant <= GW'(NUM_REQ - 1);
      owner      <= '0;
      err_q      <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        if (bc_legal && (bc_raw != 3'd1)) begin
          state      <= ST_BURST;
          beats_left <= 2'(bc_raw - 3'd1);
          owner      <= g;
        end else begin
          last_grant <= g;
        end
        if (!bc_legal) begin
          err_q[g] <= 1'b1;
        end
      end else begin
        beats_left <= beats_left - 2'd1;
        if (beats_left == 2'd1) begin
          state      <= ST_IDLE;
          last_grant <= owner;
        end
      end
    end
  end
endmodule

// File: tb/tb_avmm_ccip_wr_arbiter.sv
// tb/tb_avmm_ccip_wr_arbiter.sv - self-checking bench for avmm_ccip_wr_arbiter
module tb_avmm_ccip_wr_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 512;
  localparam int ADDR_W  = 49;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int   bursts[NUM_REQ];
  int   bc[NUM_REQ];
  int   beat[NUM_REQ];
  int   seq[NUM_REQ];
  logic fence[NUM_REQ];
  logic [NUM_REQ-1:0] acc;

  int                 m_owner;
  int                 m_rem;
  int                 m_last;
  logic [NUM_REQ-1:0] m_err;

  int   log_id[$];
  int   log_cyc[$];
  int   log_bc[$];
  logic log_fence[$];

  always #5 clk = ~clk;

  avmm_ccip_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  avmm_ccip_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit legal_bc(int b);
    return (b == 1) || (b == 2) || (b == 4);
  endfunction

  function automatic int burst_len(int b);
    return ((b == 2) || (b == 4)) ? b : 1;
  endfunction

  task automatic apply_drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_write[i]      = bursts[i] > 0;
      bus.req_burstcount[i] = 3'(bc[i]);
      bus.req_address[i]    = {fence[i], 36'h0, 4'(i), 8'(seq[i])};
      bus.req_writedata[i]  = DATA_W'(32'hD000_0000 + 32'(i * 256 + seq[i]));
    end
  endtask

  task automatic set_req(int i, int n, int b, logic f);
    bursts[i] = n;
    bc[i]     = b;
    beat[i]   = 0;
    fence[i]  = f;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 0, 1, 1'b0);
      seq[i] = 0;
    end
  endtask

  task automatic clear_log();
    log_id.delete();
    log_cyc.delete();
    log_bc.delete();
    log_fence.delete();
  endtask

  // requesters advance after each edge on which their beat was accepted
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        seq[i]++;
        beat[i]++;
        if (beat[i] >= burst_len(bc[i])) begin
          beat[i] = 0;
          bursts[i]--;
        end
      end
    end
    apply_drive();
  endtask

  task automatic wait_log(int n, string name);
    int budget;
    budget = 60;
    while (log_id.size() < n && budget > 0) begin
      step();
      budget--;
    end
    chk(name, 512'(log_id.size()), 512'(n));
  endtask

  // reference model: owner/remaining-beats view of the arbitration rules, checked every cycle
  always @(negedge clk) begin : monitor
    int                 g;
    int                 j;
    int                 obs;
    logic               exp_write;
    logic               exp_idle;
    logic [NUM_REQ-1:0] exp_wait;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) acc[i] = bus.req_write[i] && !bus.req_waitrequest[i];
    if (bus.m_write && !bus.m_waitrequest) begin
      obs = -1;
      for (int i = 0; i < NUM_REQ; i++) if (!bus.req_waitrequest[i]) obs = i;
      log_id.push_back(obs);
      log_cyc.push_back(cyc);
      log_bc.push_back(int'(bus.m_burstcount));
      log_fence.push_back(bus.m_address[48]);
    end
    if (reset) begin
      chk("rst_m_write", 512'(bus.m_write), 512'(0));
      chk("rst_idle", 512'(bus.idle), 512'(1));
      chk("rst_waitreq", 512'(bus.req_waitrequest), 512'({NUM_REQ{1'b1}}));
      chk("rst_burst_err", 512'(bus.burst_err), 512'(0));
      m_owner = -1;
      m_rem   = 0;
      m_last  = NUM_REQ - 1;
      m_err   = '0;
    end else begin
      g = -1;
      if (m_owner >= 0) begin
        g = m_owner;
      end else if (!bus.quiesce) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          j = (m_last + k) % NUM_REQ;
          if (g < 0 && bus.req_write[j]) g = j;
        end
      end
      exp_write = (g >= 0) && bus.req_write[g];
      exp_idle  = (m_owner < 0) && !exp_write;
      exp_wait  = '1;
      if (g >= 0) exp_wait[g] = bus.m_waitrequest;
      chk("m_write", 512'(bus.m_write), 512'(exp_write));
      chk("idle", 512'(bus.idle), 512'(exp_idle));
      chk("req_waitrequest", 512'(bus.req_waitrequest), 512'(exp_wait));
      chk("burst_err", 512'(bus.burst_err), 512'(m_err));
      if (exp_write) begin
        chk("m_address", 512'(bus.m_address), 512'(bus.req_address[g]));
        chk("m_writedata", 512'(bus.m_writedata), 512'(bus.req_writedata[g]));
        if (m_owner < 0) begin
          chk("m_burstcount", 512'(bus.m_burstcount),
              512'(legal_bc(int'(bus.req_burstcount[g])) ? int'(bus.req_burstcount[g]) : 1));
        end
        if (!bus.m_waitrequest) begin
          if (m_owner < 0) begin
            if (!legal_bc(int'(bus.req_burstcount[g]))) m_err[g] = 1'b1;
            if (burst_len(int'(bus.req_burstcount[g])) > 1) begin
              m_owner = g;
              m_rem   = burst_len(int'(bus.req_burstcount[g])) - 1;
            end else begin
              m_last = g;
            end
          end else begin
            m_rem--;
            if (m_rem == 0) begin
              m_last  = m_owner;
              m_owner = -1;
            end
          end
        end
      end
    end
  end

  initial begin
    bus.m_waitrequest = 1'b0;
    bus.quiesce       = 1'b0;
    acc               = '0;
    clear_reqs();
    apply_drive();
    repeat (2) @(posedge clk);
    #1;
    chk("por_m_write", 512'(bus.m_write), 512'(0));
    chk("por_idle", 512'(bus.idle), 512'(1));
    chk("por_waitreq", 512'(bus.req_waitrequest), 512'(2'b11));
    reset = 1'b0;

    // single beats from both requesters alternate with no gaps
    clear_log();
    set_req(0, 4, 1, 1'b0);
    set_req(1, 4, 1, 1'b0);
    apply_drive();
    wait_log(8, "t1_beats");
    for (int k = 0; k < 8 && k < log_id.size(); k++) begin
      chk("t1_owner", 512'(log_id[k]), 512'(k % 2));
      chk("t1_gap", 512'(log_cyc[k] - log_cyc[0]), 512'(k));
    end

    // fenced 4-beat burst from requester 1 stays contiguous, requester 0 follows at once
    clear_log();
    set_req(1, 1, 4, 1'b1);
    apply_drive();
    step();
    set_req(0, 1, 1, 1'b0);
    apply_drive();
    wait_log(5, "t2_beats");
    for (int k = 0; k < 5 && k < log_id.size(); k++) begin
      chk("t2_owner", 512'(log_id[k]), 512'((k < 4) ? 1 : 0));
      chk("t2_gap", 512'(log_cyc[k] - log_cyc[0]), 512'(k));
    end
    if (log_id.size() > 0) begin
      chk("t2_fence", 512'(log_fence[0]), 512'(1));
      chk("t2_bc", 512'(log_bc[0]), 512'(4));
    end

    // 2-beat burst stalled three cycles between beats
    clear_log();
    set_req(0, 1, 2, 1'b0);
    apply_drive();
    step();
    bus.m_waitrequest = 1'b1;
    repeat (3) step();
    bus.m_waitrequest = 1'b0;
    wait_log(2, "t3_beats");
    if (log_id.size() >= 2) chk("t3_stall_gap", 512'(log_cyc[1] - log_cyc[0]), 512'(4));
    repeat (3) step();
    chk("t3_exact_beats", 512'(log_id.size()), 512'(2));

    // quiesce mid-burst: burst completes, nothing new until quiesce drops
    clear_log();
    set_req(1, 1, 4, 1'b0);
    set_req(0, 1, 1, 1'b0);
    apply_drive();
    step();
    bus.quiesce = 1'b1;
    wait_log(4, "t4_burst");
    chk("t4_idle_after", 512'(bus.idle), 512'(1));
    chk("t4_no_grant", 512'(bus.m_write), 512'(0));
    repeat (3) step();
    chk("t4_held_off", 512'(log_id.size()), 512'(4));
    bus.quiesce = 1'b0;
    wait_log(5, "t4_resume");
    if (log_id.size() >= 5) chk("t4_next_owner", 512'(log_id[4]), 512'(0));

    // illegal burstcount 3 forwarded as a single beat and flagged sticky
    clear_log();
    set_req(0, 1, 3, 1'b0);
    apply_drive();
    wait_log(1, "t5_beat");
    if (log_id.size() >= 1) begin
      chk("t5_owner", 512'(log_id[0]), 512'(0));
      chk("t5_bc", 512'(log_bc[0]), 512'(1));
    end
    chk("t5_err", 512'(bus.burst_err), 512'(2'b01));
    set_req(1, 1, 2, 1'b0);
    set_req(0, 1, 1, 1'b0);
    apply_drive();
    wait_log(4, "t5_traffic");
    if (log_id.size() >= 4) chk("t5_last_owner", 512'(log_id[3]), 512'(0));
    chk("t5_err_sticky", 512'(bus.burst_err), 512'(2'b01));

    // asynchronous reset mid-burst drops the burst; requester 0 wins first afterwards
    clear_log();
    set_req(1, 1, 4, 1'b0);
    apply_drive();
    step();
    step();
    chk("t6_beats_before", 512'(log_id.size()), 512'(2));
    reset = 1'b1;
    #1;
    chk("t6_m_write", 512'(bus.m_write), 512'(0));
    chk("t6_idle", 512'(bus.idle), 512'(1));
    chk("t6_err_cleared", 512'(bus.burst_err), 512'(0));
    clear_reqs();
    apply_drive();
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
    set_req(0, 1, 1, 1'b0);
    set_req(1, 1, 1, 1'b0);
    apply_drive();
    wait_log(2, "t6_after");
    if (log_id.size() >= 2) begin
      chk("t6_first", 512'(log_id[0]), 512'(0));
      chk("t6_second", 512'(log_id[1]), 512'(1));
    end
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
